// File: rtl/data_plane_rx.sv
// Receive end of the data-plane link: filters packets for this node, stages 4-word messages
// and commits them atomically into a show-ahead FIFO. Optional macro: DATA_PLANE_RX_SRC_TAG_EN.
module data_plane_rx #(
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              node_id,
    input  logic [31:0]              data_rx_packet,
    input  logic                     gpp_rd_en,
    input  logic                     gpp_clr_err,
    output logic [15:0]              RAM_rx_data_out,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic [15:0]              rx_src_node,
    output logic                     data_rx_complete_flag,
    output logic                     rx_overflow,
`ifdef DATA_PLANE_RX_SRC_TAG_EN
    output logic [15:0]              rx_src_tag_out,
`endif
    output logic                     rx_abort
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef DATA_PLANE_RX_SRC_TAG_EN
    localparam int ENTRY_W = 32;
`else
    localparam int ENTRY_W = 16;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state, state_nxt;
    logic [1:0]          count;
    logic [15:0]         stage [0:2];
    logic [15:0]         src_stage;
    logic [ENTRY_W-1:0]  mem [0:DEPTH-1];
    logic [ENTRY_W-1:0]  wr_word [0:3];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                pkt_match, has_room, pop;
    logic                header_en, store_en, commit_en, overflow_set, abort_set;

    assign pkt_match = (data_rx_packet[31:16] == node_id) && (data_rx_packet != 32'h0);
    assign has_room  = (int'(rx_level) + PKT_LEN) <= DEPTH;
    assign rx_empty  = (rx_level == '0);
    assign pop       = gpp_rd_en && !rx_empty;

    always_comb begin
        state_nxt    = state;
        header_en    = 1'b0;
        store_en     = 1'b0;
        commit_en    = 1'b0;
        overflow_set = 1'b0;
        abort_set    = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_match) begin
                    header_en = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (pkt_match) begin
                    if (count == 2'(PKT_LEN - 1)) begin
                        state_nxt = IDLE;
                        if (has_room) commit_en = 1'b1;
                        else          overflow_set = 1'b1;
                    end else begin
                        store_en = 1'b1;
                    end
                end else begin
                    // Any non-matching packet, idle included, truncates the message
                    abort_set = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= 2'd0;
            src_stage <= 16'h0;
            for (int i = 0; i < 3; i++) stage[i] <= 16'h0;
        end else begin
            state <= state_nxt;
            if (header_en) begin
                src_stage <= data_rx_packet[15:0];
                count     <= 2'd0;
            end else if (store_en) begin
                count <= count + 2'd1;
            end
            for (int i = 0; i < 3; i++)
                if (store_en && count == 2'(i)) stage[i] <= data_rx_packet[15:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) wr_word[i] = '0;
`ifdef DATA_PLANE_RX_SRC_TAG_EN
        for (int i = 0; i < 3; i++) wr_word[i] = {src_stage, stage[i]};
        wr_word[3] = {src_stage, data_rx_packet[15:0]};
`else
        for (int i = 0; i < 3; i++) wr_word[i] = stage[i];
        wr_word[3] = data_rx_packet[15:0];
`endif
    end

    // wr_ptr stays 4-aligned because DEPTH is a multiple of 4, so a commit never splits across the wrap
    always_ff @(posedge clk) begin
        if (commit_en)
            for (int i = 0; i < 4; i++) mem[wr_ptr + PTR_W'(i)] <= wr_word[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            rx_level              <= '0;
            rx_src_node           <= 16'h0;
            data_rx_complete_flag <= 1'b0;
            rx_overflow           <= 1'b0;
            rx_abort              <= 1'b0;
        end else begin
            if (commit_en) begin
                wr_ptr      <= wr_ptr + PTR_W'(PKT_LEN);
                rx_src_node <= src_stage;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            rx_level <= rx_level + (commit_en ? LVL_W'(PKT_LEN) : LVL_W'(0))
                                 - (pop ? LVL_W'(1) : LVL_W'(0));
            data_rx_complete_flag <= commit_en;
            if (overflow_set)     rx_overflow <= 1'b1;
            else if (gpp_clr_err) rx_overflow <= 1'b0;
            if (abort_set)        rx_abort <= 1'b1;
            else if (gpp_clr_err) rx_abort <= 1'b0;
        end
    end

    assign RAM_rx_data_out = rx_empty ? 16'h0 : mem[rd_ptr][15:0];
`ifdef DATA_PLANE_RX_SRC_TAG_EN
    assign rx_src_tag_out  = rx_empty ? 16'h0 : mem[rd_ptr][31:16];
`endif

endmodule

// File: tb/tb_data_plane_rx.sv
// Self-checking bench for data_plane_rx: directed scenarios followed by randomized message
// traffic, all compared against a queue-based reference model.
module tb_data_plane_rx;

    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [15:0]            node_id;
    logic [31:0]            data_rx_packet;
    logic                   gpp_rd_en;
    logic                   gpp_clr_err;
    logic [15:0]            RAM_rx_data_out;
    logic                   rx_empty;
    logic [$clog2(DEPTH):0] rx_level;
    logic [15:0]            rx_src_node;
    logic                   data_rx_complete_flag;
    logic                   rx_overflow;
    logic                   rx_abort;
`ifdef DATA_PLANE_RX_SRC_TAG_EN
    logic [15:0]            rx_src_tag_out;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue of {src, data}, plus the message being collected
    logic [31:0] m_fifo [$];
    logic [15:0] m_words [$];
    bit          m_in_msg;
    logic [15:0] m_src, m_src_node;
    bit          m_flag, m_ovf, m_abort;

    data_plane_rx #(.DEPTH(DEPTH), .PKT_LEN(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .node_id               (node_id),
        .data_rx_packet        (data_rx_packet),
        .gpp_rd_en             (gpp_rd_en),
        .gpp_clr_err           (gpp_clr_err),
        .RAM_rx_data_out       (RAM_rx_data_out),
        .rx_empty              (rx_empty),
        .rx_level              (rx_level),
        .rx_src_node           (rx_src_node),
        .data_rx_complete_flag (data_rx_complete_flag),
        .rx_overflow           (rx_overflow),
`ifdef DATA_PLANE_RX_SRC_TAG_EN
        .rx_src_tag_out        (rx_src_tag_out),
`endif
        .rx_abort              (rx_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_words.delete();
        m_in_msg   = 0;
        m_src      = 16'h0;
        m_src_node = 16'h0;
        m_flag     = 0;
        m_ovf      = 0;
        m_abort    = 0;
    endfunction

    function automatic void model_edge(input logic [31:0] pkt, input bit rd, input bit clr);
        int  pre_size = m_fifo.size();
        bit  match    = (pkt[31:16] == node_id) && (pkt != 32'h0);
        bit  commit = 0, ovf_set = 0, abort_set = 0;
        if (!m_in_msg) begin
            if (match) begin
                m_src    = pkt[15:0];
                m_words.delete();
                m_in_msg = 1;
            end
        end else if (match) begin
            m_words.push_back(pkt[15:0]);
            if (m_words.size() == 4) begin
                if (DEPTH - pre_size >= 4) commit = 1;
                else ovf_set = 1;
                m_in_msg = 0;
            end
        end else begin
            abort_set = 1;
            m_in_msg  = 0;
        end
        if (rd && pre_size > 0) void'(m_fifo.pop_front());
        if (commit) begin
            foreach (m_words[i]) m_fifo.push_back({m_src, m_words[i]});
            m_src_node = m_src;
        end
        m_flag  = commit;
        m_ovf   = ovf_set   ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_abort = abort_set ? 1'b1 : (clr ? 1'b0 : m_abort);
    endfunction

    task automatic check_all();
        logic [31:0] head = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        chk("head",     32'(RAM_rx_data_out),       32'(head[15:0]));
        chk("empty",    32'(rx_empty),              32'(m_fifo.size() == 0));
        chk("level",    32'(rx_level),              32'(m_fifo.size()));
        chk("src_node", 32'(rx_src_node),           32'(m_src_node));
        chk("flag",     32'(data_rx_complete_flag), 32'(m_flag));
        chk("overflow", 32'(rx_overflow),           32'(m_ovf));
        chk("abort",    32'(rx_abort),              32'(m_abort));
`ifdef DATA_PLANE_RX_SRC_TAG_EN
        chk("src_tag",  32'(rx_src_tag_out),        32'(head[31:16]));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, sample #1 later
    task automatic applyStimulus(input logic [31:0] pkt, input bit rd = 0, input bit clr = 0);
        data_rx_packet = pkt;
        gpp_rd_en      = rd;
        gpp_clr_err    = clr;
        @(posedge clk);
        model_edge(pkt, rd, clr);
        #1;
        check_all();
    endtask

    task automatic send_msg(input logic [15:0] dest, input logic [15:0] src,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        applyStimulus({dest, src});
        applyStimulus({dest, w0});
        applyStimulus({dest, w1});
        applyStimulus({dest, w2});
        applyStimulus({dest, w3});
    endtask

    initial begin
        logic [15:0] exp_words [4];
        logic [15:0] other;
        int          kind, n;

        rst            = 1'b0;
        node_id        = 16'h0005;
        data_rx_packet = 32'h0;
        gpp_rd_en      = 1'b0;
        gpp_clr_err    = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset_empty", 32'(rx_empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Basic receive
        send_msg(16'h0005, 16'h0009, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        chk("basic_flag",  32'(data_rx_complete_flag), 32'd1);
        chk("basic_src",   32'(rx_src_node),           32'h0009);
        chk("basic_level", 32'(rx_level),              32'd4);
        applyStimulus(32'h0);
        chk("basic_flag_off", 32'(data_rx_complete_flag), 32'd0);
        exp_words[0] = 16'hAAAA; exp_words[1] = 16'hBBBB;
        exp_words[2] = 16'hCCCC; exp_words[3] = 16'hDDDD;
        for (int i = 0; i < 4; i++) begin
            chk("basic_pop", 32'(RAM_rx_data_out), 32'(exp_words[i]));
            applyStimulus(32'h0, 1);
        end
        chk("basic_drained", 32'(rx_empty), 32'd1);
        applyStimulus(32'h0, 1);
        chk("pop_on_empty", 32'(rx_level), 32'd0);

        // Address filter
        send_msg(16'h0006, 16'h0009, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        chk("filter_level", 32'(rx_level),    32'd0);
        chk("filter_flag",  32'(data_rx_complete_flag), 32'd0);
        chk("filter_abort", 32'(rx_abort),    32'd0);

        // Truncation, then a clean message
        applyStimulus(32'h00050003);
        applyStimulus(32'h00050101);
        applyStimulus(32'h00050202);
        applyStimulus(32'h0);
        chk("trunc_abort", 32'(rx_abort), 32'd1);
        chk("trunc_level", 32'(rx_level), 32'd0);
        send_msg(16'h0005, 16'h0003, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        chk("trunc_next_flag", 32'(data_rx_complete_flag), 32'd1);

        // Overflow with a full FIFO
        send_msg(16'h0005, 16'h0004, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("ovf_level8", 32'(rx_level), 32'd8);
        send_msg(16'h0005, 16'h0007, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        chk("ovf_set",   32'(rx_overflow), 32'd1);
        chk("ovf_level", 32'(rx_level),    32'd8);
        chk("ovf_noflag", 32'(data_rx_complete_flag), 32'd0);
        chk("ovf_src",   32'(rx_src_node), 32'h0004);
        applyStimulus(32'h0, 0, 1);
        chk("ovf_clr",   32'(rx_overflow), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h0, 1);
        chk("ovf_head",  32'(RAM_rx_data_out), 32'h1111);

        // Pop and commit on the same edge
        applyStimulus(32'h00050002);
        applyStimulus(32'h0005E001);
        applyStimulus(32'h0005E002);
        applyStimulus(32'h0005E003);
        applyStimulus(32'h0005E004, 1);
        chk("simul_level", 32'(rx_level),        32'd7);
        chk("simul_head",  32'(RAM_rx_data_out), 32'h2222);

        // Asynchronous reset mid-message
        applyStimulus(32'h00050011);
        applyStimulus(32'h0005F001);
        applyStimulus(32'h0005F002);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_level", 32'(rx_level), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_msg(16'h0005, 16'h0077, 16'hC001, 16'hC002, 16'hC003, 16'hC004);
        chk("async_flag", 32'(data_rx_complete_flag), 32'd1);
        chk("async_src",  32'(rx_src_node),           32'h0077);
        chk("async_head", 32'(RAM_rx_data_out),       32'hC001);

        // Randomized message traffic
        node_id = 16'($urandom_range(1, 16'hFFFF));
        other   = node_id ^ 16'h0100;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: begin
                    applyStimulus({node_id, 16'($urandom)}, $urandom_range(0, 3) == 0);
                    for (int k = 0; k < 4; k++)
                        applyStimulus({node_id, 16'($urandom)}, $urandom_range(0, 3) == 0,
                                      $urandom_range(0, 15) == 0);
                end
                2: begin
                    n = $urandom_range(0, 3);
                    applyStimulus({node_id, 16'($urandom)});
                    for (int k = 0; k < n; k++)
                        applyStimulus({node_id, 16'($urandom)}, $urandom_range(0, 1) == 0);
                    applyStimulus(($urandom_range(0, 1) == 0) ? 32'h0 : {other, 16'($urandom)});
                end
                3: begin
                    for (int k = 0; k < 5; k++)
                        applyStimulus({other, 16'($urandom)}, $urandom_range(0, 1) == 0);
                end
                default: begin
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++)
                        applyStimulus(32'h0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_plane_rx.md
Name: data_plane_rx

Overview:
- Receive end of the data-plane link; consumes the 32-bit packet stream produced by a node's data_plane_tx.
- Recognises a header packet addressed to this node, then collects the fixed-length message of 4 data packets.
- Commits each complete message atomically into a receive FIFO that the GPP drains.
- Pulses a completion flag to the control plane.

Parameters:
- DEPTH, 8, receive FIFO depth in 16-bit words; power of 2, multiple of 4, >= 4.
- PKT_LEN, 4, data packets per message; fixed system value, not to be changed.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- node_id  input  16  this node's id; 16'h0000 is reserved and never assigned
- data_rx_packet  input  32  link packet {dest[31:16], payload[15:0]}; 32'h0000 = idle
- gpp_rd_en  input  1  GPP pop request for the FIFO head
- gpp_clr_err  input  1  clears the sticky error flags
- RAM_rx_data_out  output  16  FIFO head word (show-ahead); 16'h0000 when empty
- rx_empty  output  1  FIFO empty
- rx_level  output  $clog2(DEPTH)+1  words held
- rx_src_node  output  16  source id of the last committed message
- data_rx_complete_flag  output  1  one-cycle pulse per committed message
- rx_overflow  output  1  sticky: a complete message was dropped because the FIFO lacked space
- rx_abort  output  1  sticky: a message was truncated

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, count=0, FIFO pointers and level 0.
  - All outputs 0; rx_empty=1.
  - Reset mid-message discards the staged words.
- All packets are sampled at posedge clk. A packet "matches" when data_rx_packet[31:16]==node_id and data_rx_packet!=0.
- FSM IDLE:
  - Matching packet: header. Latch payload as src_stage, count=0, go RECV.
  - Non-matching or idle packet: ignore, stay in IDLE.
- FSM RECV:
  - Matching packet: data word.
    - count<3: store payload into stage[count], count++.
    - count==3 (4th word): commit.
  - Non-matching packet (including idle 32'h0000): abort. Set rx_abort, discard the stage, go IDLE.
  - An aborting packet is not re-evaluated as a header in the same cycle.
- Commit, at the edge sampling the 4th data word:
  - Condition: DEPTH - rx_level >= 4, using the pre-edge level.
    - If true: write stage[0..2] and the current payload to FIFO in order (wr_ptr += 4); rx_src_node <= src_stage; data_rx_complete_flag=1 for the following cycle only.
    - If false: drop the whole message, set rx_overflow, no flag pulse.
  - FSM returns to IDLE either way.
- Latency: header at edge N, data at N+1..N+4; the flag is high and the words are visible during the cycle after N+4.
- Read side:
  - gpp_rd_en with !rx_empty pops the head at posedge.
  - gpp_rd_en with rx_empty is ignored and leaves state unchanged.
  - A pop and a commit on the same edge are both performed: level = level - 1 + 4.
- Pointers wrap modulo DEPTH.
- gpp_clr_err clears rx_overflow and rx_abort. If a set event occurs on the same edge, set wins.
- A header packet arriving in RECV is treated as data: a matching dest is indistinguishable from data.

Optional Feature:
- Macro: DATA_PLANE_RX_SRC_TAG_EN.
- Defined:
  - FIFO entries are 32 bits {src, data}.
  - Adds output port rx_src_tag_out[15:0], the source id of the head word; 0 when empty.
  - Per-word source survives interleaved messages from different senders.
- Undefined:
  - 16-bit entries, no extra port.
  - Only rx_src_node (last message) is available.

Test Plan:
- Basic receive: node_id=0x0005; drive 0x00050009, 0x0005AAAA, 0x0005BBBB, 0x0005CCCC, 0x0005DDDD, then 0.
  - Flag high exactly one cycle after the last word.
  - rx_src_node=0x0009, rx_level=4.
  - Pops return AAAA, BBBB, CCCC, DDDD, then rx_empty=1.
- Address filter: the same message addressed with dest 0x0006 -> no flag, rx_level stays 0, no error flags.
- Truncation: header plus 2 data words, then 0x00000000 -> rx_abort=1, rx_level=0, no flag. A following full message commits normally.
- Overflow (DEPTH=8):
  - Two full messages, no pops -> level 8.
  - A third message -> rx_overflow=1, level 8, FIFO contents unchanged, no flag.
  - gpp_clr_err -> rx_overflow=0.
- Simultaneous pop/commit: level 4; assert gpp_rd_en on the 4th-word edge of a second message -> level 7, head = word 2 of message 1.
- Async reset: assert rst=0 mid-RECV between clock edges -> outputs 0 immediately. After release, a new message is received correctly.
